// File: rtl/serial_adder_pkg.sv
// rtl/serial_adder_pkg.sv - shared state encoding and default width for the serial adder
package serial_adder_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/serial_adder_if.sv
// rtl/serial_adder_if.sv - request/result bundle between a requester and the serial adder
interface serial_adder_if
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);

   logic             start;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] sum;
   logic             cout;

   modport master (
      output start, a, b, cin,
      input  busy, done, sum, cout
   );

   modport slave (
      input  start, a, b, cin,
      output busy, done, sum, cout
   );

endinterface

// File: rtl/fulladder_1.sv
// rtl/fulladder_1.sv - one-bit full-adder cell
module fulladder_1 (
   input  logic ina,
   input  logic inb,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = ina ^ inb ^ cin;
   assign cout = (ina & inb) | (cin & (ina ^ inb));

endmodule

// File: rtl/serial_adder.sv
// rtl/serial_adder.sv - bit-serial adder, LSB first, one full-adder cell reused over WIDTH cycles
module serial_adder
   import serial_adder_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic           clk,
   input  logic           rst,
   serial_adder_if.slave  bus
);

   localparam int            CW   = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   state_t           state;
   state_t           state_nx;
   logic [WIDTH-1:0] sa;
   logic [WIDTH-1:0] sb;
   logic [WIDTH-1:0] psum;
   logic [WIDTH-1:0] sum_q;
   logic             carry;
   logic             cout_q;
   logic [CW-1:0]    cnt;
   logic             cell_sum;
   logic             cell_cout;
   logic             last_bit;

   assign last_bit = (cnt == LAST);

   fulladder_1 u_fa (
      .ina  (sa[0]),
      .inb  (sb[0]),
      .cin  (carry),
      .sum  (cell_sum),
      .cout (cell_cout)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.start) state_nx = RUN;
         RUN:     if (last_bit)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN) || (state == DONE);
      bus.done = (state == DONE);
   end

   assign bus.sum  = sum_q;
   assign bus.cout = cout_q;

   // Result registers only load on the final bit so partial sums never reach the outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sa     <= '0;
         sb     <= '0;
         psum   <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
         sum_q  <= '0;
         cout_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  sa    <= bus.a;
                  sb    <= bus.b;
                  carry <= bus.cin;
                  cnt   <= '0;
               end
            end
            RUN: begin
               sa    <= sa >> 1;
               sb    <= sb >> 1;
               psum  <= {cell_sum, psum[WIDTH-1:1]};
               carry <= cell_cout;
               if (last_bit) begin
                  sum_q  <= {cell_sum, psum[WIDTH-1:1]};
                  cout_q <= cell_cout;
               end else begin
                  cnt <= cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_adder.sv
// tb/tb_serial_adder.sv - scoreboard bench for serial_adder at WIDTH=8
module tb_serial_adder;
   import serial_adder_pkg::*;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_done = 0;

   typedef struct {
      logic [W-1:0] sum;
      logic         cout;
      int           cyc;
   } exp_t;

   exp_t         sb_q[$];
   logic [W-1:0] last_sum = '0;
   logic         last_cout = 1'b0;

   serial_adder_if #(.WIDTH(W)) bus ();

   serial_adder #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc++;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer addition, done lands WIDTH edges after acceptance.
   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic c, input int accept_cyc);
      exp_t        r;
      int unsigned total;
      total  = int'(a) + int'(b) + int'(c);
      r.sum  = W'(total % (1 << W));
      r.cout = (total >= (1 << W));
      r.cyc  = accept_cyc + W;
      return r;
   endfunction

   task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit push, input int accept_cyc);
      bus.start = 1'b1;
      bus.a     = a;
      bus.b     = b;
      bus.cin   = c;
      if (push) sb_q.push_back(model(a, b, c, accept_cyc));
   endtask

   // Entered and left on a negedge with the DUT idle.
   task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic c,
                        input bit noise);
      issue(a, b, c, 1'b1, cyc + 1);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (W + 1) begin
         if (noise) begin
            bus.start = 1'($urandom_range(1));
            bus.a     = W'($urandom);
            bus.b     = W'($urandom);
            bus.cin   = 1'($urandom_range(1));
         end
         @(negedge clk);
      end
      bus.start = 1'b0;
      check("idle_after_op", bus.busy, 0);
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         last_sum  = '0;
         last_cout = 1'b0;
      end else if (bus.done) begin
         exp_t e;
         n_done++;
         check("busy_in_done", bus.busy, 1);
         if (sb_q.size() == 0) begin
            check("unexpected_done", 1, 0);
         end else begin
            e = sb_q.pop_front();
            check("sum", bus.sum, e.sum);
            check("cout", bus.cout, e.cout);
            check("done_cycle", cyc, e.cyc);
            last_sum  = e.sum;
            last_cout = e.cout;
         end
      end else begin
         check("sum_hold", {bus.cout, bus.sum}, {last_cout, last_sum});
      end
   end

   initial begin
      int k;
      int d0;
      bus.start = 1'b0;
      bus.a     = '0;
      bus.b     = '0;
      bus.cin   = 1'b0;
      rst       = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      check("rst_sum", bus.sum, 0);
      check("rst_cout", bus.cout, 0);
      rst = 1'b0;

      do_op(8'hFF, 8'h01, 1'b0, 1'b0);
      do_op(8'hA5, 8'h5A, 1'b1, 1'b0);
      do_op(8'h3C, 8'h42, 1'b0, 1'b0);

      // start re-pulsed mid-run must be ignored
      d0 = n_done;
      k  = cyc + 1;
      issue(8'h3C, 8'h42, 1'b0, 1'b1, k);
      @(negedge clk);
      bus.start = 1'b0;
      @(negedge clk);
      issue(8'h01, 8'h01, 1'b0, 1'b0, 0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (W - 1) @(negedge clk);
      check("idle_after_repulse", bus.busy, 0);
      repeat (3) @(negedge clk);
      check("repulse_done_count", n_done - d0, 1);

      // reset while bit 4 is about to be processed
      d0 = n_done;
      issue(8'h3C, 8'h42, 1'b0, 1'b0, 0);
      @(negedge clk);
      bus.start = 1'b0;
      repeat (4) @(negedge clk);
      rst = 1'b1;
      #1;
      check("midrst_busy", bus.busy, 0);
      check("midrst_done", bus.done, 0);
      check("midrst_sum", bus.sum, 0);
      check("midrst_cout", bus.cout, 0);
      @(negedge clk);
      rst = 1'b0;
      do_op(8'h10, 8'h20, 1'b0, 1'b0);
      check("midrst_done_count", n_done - d0, 1);

      // start held high: accepted every W+2 cycles
      k = cyc + 1;
      issue(8'h11, 8'h22, 1'b0, 1'b1, k);
      @(negedge clk);
      issue(8'hF0, 8'h0F, 1'b1, 1'b1, k + W + 2);
      repeat (W + 2) @(negedge clk);
      issue(8'h80, 8'h80, 1'b0, 1'b1, k + 2 * (W + 2));
      repeat (W + 2) @(negedge clk);
      bus.start = 1'b0;
      repeat (W + 1) @(negedge clk);
      check("idle_after_held", bus.busy, 0);

      repeat (25) begin
         do_op(W'($urandom), W'($urandom), 1'($urandom_range(1)), 1'b1);
      end
      do_op(8'h00, 8'h00, 1'b0, 1'b1);
      do_op(8'hFF, 8'hFF, 1'b1, 1'b1);

      repeat (3) @(negedge clk);
      check("scoreboard_empty", sb_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter WIDTH SHALL default to 8 and set the operand width in bits; legal range 2..32.
REQ-002 Port clk, input, 1 bit, SHALL be the single clock; all state updates occur on its rising edge.
REQ-003 Port rst, input, 1 bit, SHALL be the asynchronous, active-high reset.
REQ-004 Port start, input, 1 bit, SHALL request a new addition; it is sampled only in IDLE.
REQ-005 Port a, input, WIDTH bits, SHALL be operand A, captured when start is accepted.
REQ-006 Port b, input, WIDTH bits, SHALL be operand B, captured when start is accepted.
REQ-007 Port cin, input, 1 bit, SHALL be the carry-in, captured when start is accepted.
REQ-008 Port busy, output, 1 bit, SHALL be high in RUN and DONE.
REQ-009 Port done, output, 1 bit, SHALL be a one-cycle pulse that is high only in DONE.
REQ-010 Port sum, output, WIDTH bits, SHALL be the registered result of the last completed addition.
REQ-011 Port cout, output, 1 bit, SHALL be the registered carry-out of the last completed addition.

Function
REQ-012 The FSM SHALL have three states: IDLE, RUN and DONE.
- IDLE->RUN on start=1.
- RUN->DONE on the edge processing bit WIDTH-1.
- DONE->IDLE unconditionally.
REQ-013 On start acceptance the block SHALL load shift registers sa<=a and sb<=b, set carry<=cin and set bit counter<=0.
REQ-014 Each RUN cycle SHALL add sa[0], sb[0] and carry through one full-adder cell, LSB first.
- The partial-sum register shifts right with the cell sum entering at its MSB.
- carry<=cell carry-out.
- sa and sb shift right, filling with 0.
- counter increments.
REQ-015 On the final RUN edge (counter==WIDTH-1) the block SHALL update sum with the completed partial-sum value and cout with the final cell carry-out.
REQ-016 Latency SHALL be fixed: start is sampled at edge k, RUN covers edges k+1..k+WIDTH, and done plus the new sum/cout are visible after edge k+WIDTH.
REQ-017 sum and cout SHALL hold their value from completion until the next completion; partial results SHALL never appear on sum.
REQ-018 start asserted in RUN or DONE SHALL be ignored, with no queuing and no effect on the operation in progress.
REQ-019 start held high continuously SHALL give back-to-back operations of WIDTH+2 cycles each, with a new start accepted in the IDLE cycle after DONE.
REQ-020 a, b and cin changing after acceptance SHALL NOT affect the result.
REQ-021 The result SHALL equal (a + b + cin) modulo 2^WIDTH, and cout SHALL be bit WIDTH of the true sum.
REQ-022 The counter SHALL be $clog2(WIDTH) bits wide and SHALL NOT wrap within an operation.

Reset
REQ-023 Asserting rst SHALL immediately force the state to IDLE and clear sa, sb, the partial sum, carry, counter, sum and cout to 0, so busy=0 and done=0.
REQ-024 Reset mid-operation SHALL abandon the operation, with no done pulse and sum/cout reading 0.
REQ-025 The first start SHALL be accepted on the first rising clk edge after rst deasserts.

Structure
REQ-026 A shared package, serial_adder_pkg, SHALL hold the state encodings (IDLE, RUN, DONE) and the default WIDTH constant.
REQ-027 The per-bit addition SHALL be done by one instance of the existing 1-bit full-adder cell, fulladder_1, with ports ina, inb, cin, sum and cout.
REQ-028 All remaining logic SHALL be a single sequential process plus next-state logic.

Verification (WIDTH=8)
REQ-029 The bench SHALL cover: rst pulse -> busy=0, done=0, sum=8'h00, cout=0.
REQ-030 The bench SHALL cover: a=8'hFF, b=8'h01, cin=0, start one cycle -> done exactly 8 edges after the start edge, sum=8'h00, cout=1.
REQ-031 The bench SHALL cover: a=8'hA5, b=8'h5A, cin=1 -> sum=8'h00, cout=1; a=8'h3C, b=8'h42, cin=0 -> sum=8'h7E, cout=0.
REQ-032 The bench SHALL cover: start re-pulsed in RUN with a=8'h01, b=8'h01 during an 8'h3C+8'h42 operation -> result 8'h7E with exactly one done pulse.
REQ-033 The bench SHALL cover: rst at RUN bit 4 -> no done pulse, sum=8'h00; next 8'h10+8'h20 -> 8'h30.
REQ-034 The bench SHALL cover: start held high for 3 operations -> done pulses spaced 10 cycles apart, and each sum holds until the next done.
